// File: rtl/touch_panel_sampler.sv
// touch_panel_sampler
// Polls an ADS7843-style touch controller through the register port of an 8-bit
// SPI master while the pen is down, and presents assembled 12-bit X/Y pairs.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   pen_irq_n            raw pen interrupt from the controller (active low, async)
//   spi_select ..        register-port master side of the SPI core (3-cycle accesses)
//   spi_rd_data          SPI read data, valid in the 2nd cycle of a read access
//   spi_dataavailable    RRDY; spi_readyfordata: TRDY
//   x_pos, y_pos         last presented coordinate pair
//   sample_valid/ready   output handshake for the pair
//   pen_down             synchronized pen state
//   busy                 high while a poll sequence or slave setup is in progress
module touch_panel_sampler #(
  parameter int unsigned SAMPLE_DIV = 500000,
  parameter logic [7:0]  CMD_X      = 8'hD0,
  parameter logic [7:0]  CMD_Y      = 8'h90,
  parameter logic [15:0] SLAVE_MASK = 16'h0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pen_irq_n,
  output logic        spi_select,
  output logic [2:0]  spi_mem_addr,
  output logic        spi_read_n,
  output logic        spi_write_n,
  output logic [15:0] spi_wr_data,
  input  logic [15:0] spi_rd_data,
  input  logic        spi_dataavailable,
  input  logic        spi_readyfordata,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        pen_down,
  output logic        busy
);

  localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [3:0] {
    StIdle, StWaitTick, StSetSlave, StSsoOn, StWaitTrdy,
    StWrByte, StWaitRrdy, StRdByte, StSsoOff, StPresent
  } state_e;

  // Pen synchronizer; reset to "pen up" so pen_down resets low.
  logic pen_meta_q, pen_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pen_meta_q <= 1'b1;
      pen_sync_q <= 1'b1;
    end else begin
      pen_meta_q <= pen_irq_n;
      pen_sync_q <= pen_meta_q;
    end
  end

  assign pen_down = ~pen_sync_q;

  // Sample-rate divider, free-running only while the pen is down.
  logic [CntW-1:0] tick_cnt_q;
  logic            tick_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (!pen_down) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (tick_cnt_q == CntW'(SAMPLE_DIV - 1)) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_q + CntW'(1);
      tick_q     <= 1'b0;
    end
  end

  state_e      state_q;
  logic [1:0]  phase_q;     // position within a 3-cycle bus access
  logic        axis_y_q;
  logic [1:0]  byte_idx_q;
  logic [7:0]  hi_q, lo_q;
  logic [11:0] hold_x_q, hold_y_q;

  logic        in_access;
  logic        acc_done;
  logic [7:0]  tx_byte;
  logic [11:0] result;
  logic        unused_bits;

  assign in_access = (state_q == StSetSlave) || (state_q == StSsoOn) ||
                     (state_q == StWrByte) || (state_q == StRdByte) ||
                     (state_q == StSsoOff);
  assign acc_done  = in_access && (phase_q == 2'd2);
  assign tx_byte   = (byte_idx_q == 2'd0) ? (axis_y_q ? CMD_Y : CMD_X) : 8'h00;
  assign result    = {hi_q[6:0], lo_q[7:3]};
  assign busy      = (state_q != StIdle) && (state_q != StWaitTick);
  assign unused_bits = ^{spi_rd_data[15:8], hi_q[7], lo_q[2:0]};

  // Launch a bus access: strobes go live on the next cycle, phase restarts.
  task automatic start_access(input logic [2:0] addr, input logic rd, input logic [15:0] data);
    spi_select   <= 1'b1;
    spi_mem_addr <= addr;
    spi_read_n   <= ~rd;
    spi_write_n  <= rd;
    spi_wr_data  <= data;
    phase_q      <= 2'd0;
  endtask

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= 2'd0;
      axis_y_q     <= 1'b0;
      byte_idx_q   <= 2'd0;
      hi_q         <= 8'h00;
      lo_q         <= 8'h00;
      hold_x_q     <= 12'h000;
      hold_y_q     <= 12'h000;
      spi_select   <= 1'b0;
      spi_mem_addr <= 3'd0;
      spi_read_n   <= 1'b1;
      spi_write_n  <= 1'b1;
      spi_wr_data  <= 16'h0000;
      x_pos        <= 12'h000;
      y_pos        <= 12'h000;
      sample_valid <= 1'b0;
    end else begin
      if (sample_valid && sample_ready) sample_valid <= 1'b0;

      // Cycles 1-2 strobed, cycle 3 idle; the phase parks at 2 until the next launch.
      if (in_access && phase_q != 2'd2) phase_q <= phase_q + 2'd1;
      if (in_access && phase_q == 2'd1) begin
        spi_select  <= 1'b0;
        spi_read_n  <= 1'b1;
        spi_write_n <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          state_q <= StSetSlave;
          start_access(3'd5, 1'b0, SLAVE_MASK);
        end
        StSetSlave: if (acc_done) state_q <= StWaitTick;
        StWaitTick: begin
          if (tick_q && pen_down) begin
            axis_y_q   <= 1'b0;
            byte_idx_q <= 2'd0;
            state_q    <= StSsoOn;
            start_access(3'd3, 1'b0, 16'h0400);
          end
        end
        StSsoOn: if (acc_done) state_q <= StWaitTrdy;
        StWaitTrdy: begin
          if (spi_readyfordata) begin
            state_q <= StWrByte;
            start_access(3'd1, 1'b0, {8'h00, tx_byte});
          end
        end
        StWrByte: if (acc_done) state_q <= StWaitRrdy;
        StWaitRrdy: begin
          if (spi_dataavailable) begin
            state_q <= StRdByte;
            start_access(3'd0, 1'b1, 16'h0000);
          end
        end
        StRdByte: begin
          // Read data is registered in the SPI core: sample at the end of cycle 2.
          if (phase_q == 2'd1) begin
            if (byte_idx_q == 2'd1) hi_q <= spi_rd_data[7:0];
            if (byte_idx_q == 2'd2) lo_q <= spi_rd_data[7:0];
          end
          if (acc_done) begin
            if (byte_idx_q == 2'd2) begin
              if (axis_y_q) hold_y_q <= result;
              else          hold_x_q <= result;
              state_q <= StSsoOff;
              start_access(3'd3, 1'b0, 16'h0000);
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              state_q    <= StWaitTrdy;
            end
          end
        end
        StSsoOff: begin
          if (acc_done) begin
            if (!axis_y_q) begin
              axis_y_q   <= 1'b1;
              byte_idx_q <= 2'd0;
              state_q    <= StSsoOn;
              start_access(3'd3, 1'b0, 16'h0400);
            end else begin
              state_q <= StPresent;
            end
          end
        end
        StPresent: begin
          if (!sample_valid) begin
            x_pos        <= hold_x_q;
            y_pos        <= hold_y_q;
            sample_valid <= 1'b1;
            state_q      <= StWaitTick;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_touch_panel_sampler.sv
module tb_touch_panel_sampler;

  localparam int unsigned SDIV = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        pen_irq_n;
  logic        spi_select;
  logic [2:0]  spi_mem_addr;
  logic        spi_read_n;
  logic        spi_write_n;
  logic [15:0] spi_wr_data;
  logic [15:0] spi_rd_data;
  logic        spi_dataavailable;
  logic        spi_readyfordata;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        sample_valid;
  logic        sample_ready;
  logic        pen_down;
  logic        busy;

  always #5 clk = ~clk;

  touch_panel_sampler #(
    .SAMPLE_DIV (SDIV),
    .CMD_X      (8'hD0),
    .CMD_Y      (8'h90),
    .SLAVE_MASK (16'h0001)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pen_irq_n         (pen_irq_n),
    .spi_select        (spi_select),
    .spi_mem_addr      (spi_mem_addr),
    .spi_read_n        (spi_read_n),
    .spi_write_n       (spi_write_n),
    .spi_wr_data       (spi_wr_data),
    .spi_rd_data       (spi_rd_data),
    .spi_dataavailable (spi_dataavailable),
    .spi_readyfordata  (spi_readyfordata),
    .x_pos             (x_pos),
    .y_pos             (y_pos),
    .sample_valid      (sample_valid),
    .sample_ready      (sample_ready),
    .pen_down          (pen_down),
    .busy              (busy)
  );

  typedef struct packed {
    logic        rd;
    logic [2:0]  addr;
    logic [15:0] data;
  } acc_t;

  acc_t        exp_q[$];
  logic [7:0]  resp_q[$];
  logic [23:0] pair_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int acc_count = 0;
  int pair_count = 0;
  int cyc = 0;
  int rrdy_delay = 0;
  int pending = 0;
  int rise_cyc = 0;
  int base;
  int pbase;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input string tag, input int n, input int budget);
    int k = 0;
    while (acc_count < n && k < budget) begin
      cycles(1);
      k++;
    end
    check(tag, 64'(acc_count >= n), 64'd1);
  endtask

  task automatic wait_pairs(input string tag, input int n, input int budget);
    int k = 0;
    while (pair_count < n && k < budget) begin
      cycles(1);
      k++;
    end
    check(tag, 64'(pair_count >= n), 64'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (sample_valid !== 1'b1 && k < budget) begin
      cycles(1);
      k++;
    end
    check(tag, 64'(sample_valid), 64'd1);
  endtask

  task automatic push_acc(input logic rd, input logic [2:0] a, input logic [15:0] d);
    acc_t e;
    e.rd   = rd;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic logic [11:0] coord(input logic [7:0] h, input logic [7:0] l);
    return {h[6:0], l[7:3]};
  endfunction

  task automatic push_axis(input logic [7:0] cmd);
    push_acc(1'b0, 3'd3, 16'h0400);
    push_acc(1'b0, 3'd1, {8'h00, cmd});
    push_acc(1'b1, 3'd0, 16'h0000);
    push_acc(1'b0, 3'd1, 16'h0000);
    push_acc(1'b1, 3'd0, 16'h0000);
    push_acc(1'b0, 3'd1, 16'h0000);
    push_acc(1'b1, 3'd0, 16'h0000);
    push_acc(1'b0, 3'd3, 16'h0000);
  endtask

  task automatic push_pair(input logic [7:0] xj, input logic [7:0] xh, input logic [7:0] xl,
                           input logic [7:0] yj, input logic [7:0] yh, input logic [7:0] yl);
    push_axis(8'hD0);
    push_axis(8'h90);
    resp_q.push_back(xj);
    resp_q.push_back(xh);
    resp_q.push_back(xl);
    resp_q.push_back(yj);
    resp_q.push_back(yh);
    resp_q.push_back(yl);
    pair_q.push_back({coord(xh, xl), coord(yh, yl)});
  endtask

  // SPI master model and bus/output monitor; samples late in each cycle.
  initial begin : spi_model
    logic        prev_sel;
    logic        prev_rst;
    int          sel_len;
    acc_t        got;
    acc_t        want;
    logic [7:0]  b;
    logic [23:0] want_p;
    prev_sel = 1'b0;
    prev_rst = 1'b0;
    sel_len  = 0;
    spi_dataavailable = 1'b0;
    spi_rd_data       = 16'h0000;
    spi_readyfordata  = 1'b1;
    forever begin
      @(posedge clk);
      #3;
      cyc++;
      if (reset) begin
        if (!prev_rst) begin
          resp_q.delete();
          pending = 0;
          spi_dataavailable = 1'b0;
          spi_rd_data = 16'h0000;
        end
        prev_rst = 1'b1;
        prev_sel = 1'b0;
      end else begin
        prev_rst = 1'b0;
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            spi_dataavailable = 1'b1;
            rise_cyc = cyc;
          end
        end
        if (spi_select && !prev_sel) begin
          acc_count++;
          sel_len = 1;
          check("strobe_exclusive", 64'(spi_read_n ^ spi_write_n), 64'd1);
          got.rd   = ~spi_read_n;
          got.addr = spi_mem_addr;
          got.data = got.rd ? 16'h0000 : spi_wr_data;
          if (exp_q.size() == 0) begin
            check("access_unexpected", 64'(exp_q.size()), 64'd1);
          end else begin
            want = exp_q.pop_front();
            check("access", 64'(got), 64'(want));
          end
          if (!got.rd && got.addr == 3'd1) begin
            b = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
            spi_rd_data = {8'h00, b};
            if (rrdy_delay == 0) spi_dataavailable = 1'b1;
            else pending = rrdy_delay;
          end
          if (got.rd && got.addr == 3'd0) begin
            if (rrdy_delay > 0) check("read_after_rrdy", 64'(cyc - rise_cyc), 64'd1);
            spi_dataavailable = 1'b0;
          end
        end else if (spi_select) begin
          sel_len++;
        end else if (prev_sel) begin
          check("access_len", 64'(sel_len), 64'd2);
          check("strobes_idle", 64'({spi_read_n, spi_write_n}), 64'd3);
        end
        if (sample_valid && sample_ready) begin
          pair_count++;
          if (pair_q.size() == 0) begin
            check("pair_unexpected", 64'(pair_q.size()), 64'd1);
          end else begin
            want_p = pair_q.pop_front();
            check("pair", 64'({x_pos, y_pos}), 64'(want_p));
          end
        end
        prev_sel = spi_select;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : main
    reset        = 1'b1;
    pen_irq_n    = 1'b1;
    sample_ready = 1'b0;

    // Reset values and the single slave-select write.
    cycles(3);
    check("reset_outputs",
          64'({spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_wr_data,
               x_pos, y_pos, sample_valid, pen_down, busy}),
          64'({1'b0, 1'b1, 1'b1, 3'd0, 16'h0000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0}));
    push_acc(1'b0, 3'd5, 16'h0001);
    reset = 1'b0;
    cycles(2 * SDIV);
    check("idle_accesses", 64'(acc_count), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_queue", 64'(exp_q.size()), 64'd0);

    // One pair, pen lifted during X conversion.
    base = acc_count;
    push_pair(8'h5C, 8'h3A, 8'hB8, 8'hA5, 8'h12, 8'h40);
    pen_irq_n = 1'b0;
    cycles(1);
    check("pen_down_early", 64'(pen_down), 64'd0);
    cycles(1);
    check("pen_down", 64'(pen_down), 64'd1);
    wait_acc("pair1_start", base + 1, SDIV + 20);
    pen_irq_n = 1'b1;
    wait_valid("pair1_valid", 2000);
    check("pair1_x", 64'(x_pos), 64'h757);
    check("pair1_y", 64'(y_pos), 64'h248);
    sample_ready = 1'b1;
    cycles(2);
    check("pair1_valid_clear", 64'(sample_valid), 64'd0);
    cycles(2 * SDIV);
    check("pair1_accesses", 64'(acc_count - base), 64'd16);
    check("pair1_busy", 64'(busy), 64'd0);
    sample_ready = 1'b0;

    // Back-pressure across two pairs.
    base  = acc_count;
    pbase = pair_count;
    push_pair(8'h11, 8'h55, 8'hF0, 8'h22, 8'h01, 8'h07);
    push_pair(8'h33, 8'h7F, 8'hFF, 8'h44, 8'h80, 8'h00);
    pen_irq_n = 1'b0;
    wait_valid("bp_valid1", SDIV + 2000);
    check("bp_x1", 64'(x_pos), 64'hABE);
    check("bp_y1", 64'(y_pos), 64'h020);
    wait_acc("bp_second_start", base + 17, 2 * SDIV + 200);
    pen_irq_n = 1'b1;
    wait_acc("bp_second_done", base + 32, 2000);
    cycles(20);
    check("bp_hold_valid", 64'(sample_valid), 64'd1);
    check("bp_hold_x", 64'(x_pos), 64'hABE);
    check("bp_hold_y", 64'(y_pos), 64'h020);
    check("bp_stall_busy", 64'(busy), 64'd1);
    sample_ready = 1'b1;
    cycles(1);
    check("bp_gap_valid", 64'(sample_valid), 64'd0);
    check("bp_gap_x", 64'(x_pos), 64'hABE);
    cycles(1);
    check("bp_load_valid", 64'(sample_valid), 64'd1);
    check("bp_load_x", 64'(x_pos), 64'hFFF);
    check("bp_load_y", 64'(y_pos), 64'h000);
    cycles(2);
    check("bp_pairs", 64'(pair_count - pbase), 64'd2);
    cycles(2 * SDIV);
    check("bp_accesses", 64'(acc_count - base), 64'd32);

    // Slow RRDY: reads must follow its rise by exactly one cycle.
    base  = acc_count;
    pbase = pair_count;
    rrdy_delay = 800;
    push_pair(8'h00, 8'h40, 8'h08, 8'hFF, 8'h3F, 8'hF8);
    pen_irq_n = 1'b0;
    wait_acc("slow_start", base + 1, SDIV + 20);
    pen_irq_n = 1'b1;
    cycles(400);
    check("slow_no_early_read", 64'(acc_count - base), 64'd2);
    check("slow_busy", 64'(busy), 64'd1);
    wait_pairs("slow_pair", pbase + 1, 8000);
    check("slow_accesses", 64'(acc_count - base), 64'd16);
    check("slow_x", 64'(x_pos), 64'h801);
    check("slow_y", 64'(y_pos), 64'h7FF);
    rrdy_delay = 0;

    // Reset during the second byte of Y.
    base  = acc_count;
    pbase = pair_count;
    push_pair(8'h00, 8'h3A, 8'hB8, 8'h00, 8'h12, 8'h40);
    pen_irq_n = 1'b0;
    wait_acc("rst_ybyte", base + 12, SDIV + 500);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_outputs",
          64'({spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_wr_data,
               x_pos, y_pos, sample_valid, pen_down, busy}),
          64'({1'b0, 1'b1, 1'b1, 3'd0, 16'h0000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0}));
    cycles(3);
    exp_q.delete();
    pair_q.delete();
    base = acc_count;
    push_acc(1'b0, 3'd5, 16'h0001);
    push_pair(8'h01, 8'h7F, 8'h00, 8'h02, 8'h00, 8'hF8);
    reset = 1'b0;
    wait_acc("rst_resume", base + 2, SDIV + 50);
    pen_irq_n = 1'b1;
    wait_pairs("rst_pair", pbase + 1, 2000);
    check("rst_x", 64'(x_pos), 64'hFE0);
    check("rst_y", 64'(y_pos), 64'h01F);
    cycles(2 * SDIV);
    check("rst_accesses", 64'(acc_count - base), 64'd17);
    check("rst_busy", 64'(busy), 64'd0);
    check("final_acc_queue", 64'(exp_q.size()), 64'd0);
    check("final_pair_queue", 64'(pair_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
